ifm_tile_stream: RTL and testbench

Transmit-side counterpart of the accelerator's OFM un-tiler. Accepts an input feature map in raster order into a ping-pong frame buffer, then replays it as column tiles on two parallel row ports (port0 = even row, port1 = odd row) with per-port valid and a shared ready. Sits between the host-side IFM loader and the PE array input. Loading of one frame overlaps streaming of the previous one.

---
 rtl/ifm_tile_stream_if.sv | 34 +++
 rtl/ifm_tile_stream.sv | 217 +++++++++++++++++++++
 tb/tb_ifm_tile_stream.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifm_tile_stream_if.sv
// ifm_tile_stream_if: load stream plus dual-row tiled output bundle.
// tile_last exists only when IFM_TILE_LAST_EN is defined.
interface ifm_tile_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  load_v;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;
    logic                  out_ready;
    logic                  port0_v;
    logic                  port1_v;
    logic [DATA_WIDTH-1:0] port0;
    logic [DATA_WIDTH-1:0] port1;
    logic                  frame_done;
`ifdef IFM_TILE_LAST_EN
    logic                  tile_last;
`endif

    modport master (
`ifdef IFM_TILE_LAST_EN
        input  tile_last,
`endif
        output load_v, load_data, out_ready,
        input  load_ready, port0_v, port1_v, port0, port1, frame_done
    );

    modport slave (
`ifdef IFM_TILE_LAST_EN
        output tile_last,
`endif
        input  load_v, load_data, out_ready,
        output load_ready, port0_v, port1_v, port0, port1, frame_done
    );
endinterface

// File: rtl/ifm_tile_stream.sv
// ifm_tile_stream: ping-pong IFM frame buffer replayed as column tiles on two row ports.
// Define IFM_TILE_LAST_EN to add tile_last on the final beat of every tile.
module ifm_tile_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int IW         = 64,
    parameter int IH         = 64,
    parameter int TILE_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    ifm_tile_stream_if.slave bus
);
    localparam int FRAME = IW * IH;
    localparam int AW    = $clog2(2 * FRAME);
    localparam int FAW   = $clog2(FRAME + 1);
    localparam int NT    = IW / TILE_W;
    localparam int NRP   = (IH + 1) / 2;
    localparam int TWW   = $clog2(NT + 1);
    localparam int RPW   = $clog2(NRP + 1);
    localparam int OWW   = $clog2(TILE_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [2*FRAME];

    logic [1:0]            r_full;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [FAW-1:0]        r_wr_addr;

    state_t                r_state;
    state_t                w_next;

    logic [TWW-1:0]        r_tw;
    logic [RPW-1:0]        r_rp;
    logic [OWW-1:0]        r_ow;

    logic                  r_p0v;
    logic                  r_p1v;
    logic [DATA_WIDTH-1:0] r_p0;
    logic [DATA_WIDTH-1:0] r_p1;
    logic                  r_fd;

    logic                  w_load;
    logic                  w_wr_last;
    logic [AW-1:0]         w_wa;
    logic                  w_adv;
    logic                  w_issue;
    logic                  w_release;
    logic                  w_last;
    logic                  w_has1;
    logic [AW-1:0]         w_a0;
    logic [AW-1:0]         w_a1;
    int                    w_col;
    int                    w_row0;

`ifdef IFM_TILE_LAST_EN
    logic                  r_tl;
    logic                  w_tl;
`endif

    // ---------------- load side ----------------
    assign bus.load_ready = !r_full[r_wr_bank];
    assign w_load         = bus.load_v && !r_full[r_wr_bank];
    assign w_wr_last      = (r_wr_addr == FAW'(FRAME - 1));
    assign w_wa           = AW'(int'(r_wr_bank) * FRAME + int'(r_wr_addr));

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_mem[w_wa] <= bus.load_data;
        end
    end

    // Set and clear always target different banks: a full write bank blocks loading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_addr <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_full    <= '0;
        end else begin
            if (w_load) begin
                if (w_wr_last) begin
                    r_wr_addr           <= '0;
                    r_wr_bank           <= ~r_wr_bank;
                    r_full[r_wr_bank]   <= 1'b1;
                end else begin
                    r_wr_addr <= r_wr_addr + FAW'(1);
                end
            end
            if (w_release) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
        end
    end

    // ---------------- read addressing ----------------
    always_comb begin
        w_col  = int'(r_tw) * TILE_W + int'(r_ow);
        w_row0 = 2 * int'(r_rp);
        w_has1 = (w_row0 + 1) < IH;
        w_a0   = AW'(int'(r_rd_bank) * FRAME + w_row0 * IW + w_col);
        w_a1   = w_has1 ? AW'(int'(w_a0) + IW) : w_a0;
        w_last = (r_tw == TWW'(NT - 1)) &&
                 (r_rp == RPW'(NRP - 1)) &&
                 (r_ow == OWW'(TILE_W - 1));
    end

`ifdef IFM_TILE_LAST_EN
    assign w_tl = (r_rp == RPW'(NRP - 1)) &&
                  (r_ow == OWW'(TILE_W - 1));
`endif

    // ---------------- stream FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DRAIN jumps straight back to STREAM when the other bank is ready,
    // keeping the inter-frame gap to the single frame_done cycle.
    always_comb begin
        w_next    = r_state;
        w_adv     = !r_p0v || bus.out_ready;
        w_issue   = 1'b0;
        w_release = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_adv) begin
                    w_issue = 1'b1;
                    if (w_last) begin
                        w_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.out_ready) begin
                    w_release = 1'b1;
                    w_next    = r_full[~r_rd_bank] ? S_STREAM : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- beat counters and output registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tw  <= '0;
            r_rp  <= '0;
            r_ow  <= '0;
            r_p0v <= 1'b0;
            r_p1v <= 1'b0;
            r_p0  <= '0;
            r_p1  <= '0;
            r_fd  <= 1'b0;
`ifdef IFM_TILE_LAST_EN
            r_tl  <= 1'b0;
`endif
        end else begin
            r_fd <= w_release;
            if (w_issue) begin
                r_p0v <= 1'b1;
                r_p1v <= w_has1;
                r_p0  <= r_mem[w_a0];
                r_p1  <= w_has1 ? r_mem[w_a1] : '0;
`ifdef IFM_TILE_LAST_EN
                r_tl  <= w_tl;
`endif
                if (r_ow == OWW'(TILE_W - 1)) begin
                    r_ow <= '0;
                    if (r_rp == RPW'(NRP - 1)) begin
                        r_rp <= '0;
                        if (r_tw == TWW'(NT - 1)) begin
                            r_tw <= '0;
                        end else begin
                            r_tw <= r_tw + TWW'(1);
                        end
                    end else begin
                        r_rp <= r_rp + RPW'(1);
                    end
                end else begin
                    r_ow <= r_ow + OWW'(1);
                end
            end else if (w_release) begin
                r_p0v <= 1'b0;
                r_p1v <= 1'b0;
`ifdef IFM_TILE_LAST_EN
                r_tl  <= 1'b0;
`endif
            end
        end
    end

    assign bus.port0_v    = r_p0v;
    assign bus.port1_v    = r_p1v;
    assign bus.port0      = r_p0;
    assign bus.port1      = r_p1;
    assign bus.frame_done = r_fd;
`ifdef IFM_TILE_LAST_EN
    assign bus.tile_last  = r_tl;
`endif

endmodule

// File: tb/tb_ifm_tile_stream.sv
// Bench for ifm_tile_stream: even-height and odd-height instances checked
// against a frame-queue model of the tiled two-row replay order.
`timescale 1ns/1ps
module tb_ifm_tile_stream;
    localparam int IWP  = 8;
    localparam int TWP  = 4;
    localparam int NBUF = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       ld_v [2];
    logic [7:0] ld_d [2];
    logic       ordy [2];
    logic       lrdy [2];
    logic       p0v  [2];
    logic       p1v  [2];
    logic [7:0] p0   [2];
    logic [7:0] p1   [2];
    logic       fd   [2];
    logic       tl   [2];

    ifm_tile_stream_if #(.DATA_WIDTH(8)) ia ();
    ifm_tile_stream_if #(.DATA_WIDTH(8)) ib ();

    ifm_tile_stream #(.DATA_WIDTH(8), .IW(8), .IH(4), .TILE_W(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    ifm_tile_stream #(.DATA_WIDTH(8), .IW(8), .IH(3), .TILE_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    assign ia.load_v    = ld_v[0];
    assign ia.load_data = ld_d[0];
    assign ia.out_ready = ordy[0];
    assign ib.load_v    = ld_v[1];
    assign ib.load_data = ld_d[1];
    assign ib.out_ready = ordy[1];

    assign lrdy[0] = ia.load_ready;
    assign p0v[0]  = ia.port0_v;
    assign p1v[0]  = ia.port1_v;
    assign p0[0]   = ia.port0;
    assign p1[0]   = ia.port1;
    assign fd[0]   = ia.frame_done;
    assign lrdy[1] = ib.load_ready;
    assign p0v[1]  = ib.port0_v;
    assign p1v[1]  = ib.port1_v;
    assign p0[1]   = ib.port0;
    assign p1[1]   = ib.port1;
    assign fd[1]   = ib.frame_done;
`ifdef IFM_TILE_LAST_EN
    assign tl[0] = ia.tile_last;
    assign tl[1] = ib.tile_last;
`else
    assign tl[0] = 1'b0;
    assign tl[1] = 1'b0;
`endif

    // model state
    logic [7:0] pbuf [2][NBUF];
    int   head [2];
    int   cnt  [2];
    int   beat [2];
    int   tot  [2];
    int   fdn  [2];
    int   wcnt [2];
    int   wbnd [2];
    int   fgap [2];
    logic fdx  [2];
    logic mid  [2];
    logic [7:0] ob0  [2][32];
    logic [7:0] ob1  [2][32];
    logic       ob1v [2][32];
    logic       obtl [2][32];

    int n_cmp = 0;
    int n_bad = 0;

    // driver state
    int ld_sent [2];
    int target  [2];
    bit rnd;
    int omode;
    int cyc;

    function automatic int fsz(input int k);
        return (k == 0) ? 32 : 24;
    endfunction

    function automatic int ihs(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int nbeats(input int k);
        return (IWP / TWP) * ((ihs(k) + 1) / 2) * TWP;
    endfunction

    function automatic logic [7:0] px(input int k, input int i);
        return pbuf[k][(head[k] + i) % NBUF];
    endfunction

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    // compare process: outputs are stable here, half a cycle from the active edge
    always @(negedge clk) begin
        int f, b, nrp, tw, rem, rp, ow, col, e0, e1;
        bit av, lre, e1v;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                chk("rst_port0_v", k, p0v[k], 0);
                chk("rst_port1_v", k, p1v[k], 0);
                chk("rst_load_ready", k, lrdy[k], 1);
                chk("rst_frame_done", k, fd[k], 0);
                chk("rst_port0", k, p0[k], 0);
                chk("rst_port1", k, p1[k], 0);
                head[k] = 0; cnt[k] = 0; beat[k] = 0;
                fdx[k] = 1'b0; mid[k] = 1'b0;
                wcnt[k] = 0; wbnd[k] = 2;
            end else begin
                f   = fsz(k);
                av  = cnt[k] >= f;
                lre = cnt[k] < 2 * f;
                chk("frame_done", k, fd[k], fdx[k]);
                chk("load_ready", k, lrdy[k], lre);
                if (fd[k]) fdn[k]++;
                fdx[k] = 1'b0;
                if (!p0v[k]) chk("port1_v_alone", k, p1v[k], 0);
                if (p0v[k]) begin
                    chk("valid_has_frame", k, av, 1);
                    if (av) begin
                        b   = beat[k];
                        nrp = (ihs(k) + 1) / 2;
                        tw  = b / (nrp * TWP);
                        rem = b % (nrp * TWP);
                        rp  = rem / TWP;
                        ow  = rem % TWP;
                        col = tw * TWP + ow;
                        e0  = px(k, 2 * rp * IWP + col);
                        e1v = (2 * rp + 1) < ihs(k);
                        e1  = e1v ? int'(px(k, (2 * rp + 1) * IWP + col)) : 0;
                        chk("port0", k, p0[k], e0);
                        chk("port1_v", k, p1v[k], e1v);
                        chk("port1", k, p1[k], e1);
`ifdef IFM_TILE_LAST_EN
                        chk("tile_last", k, tl[k], (rp == nrp - 1) && (ow == TWP - 1));
`endif
                        if (tot[k] == 0) begin
                            ob0[k][b]  = p0[k];
                            ob1[k][b]  = p1[k];
                            ob1v[k][b] = p1v[k];
                            obtl[k][b] = tl[k];
                        end
                    end
                    if (wcnt[k] > 0 && tot[k] == 0 && beat[k] == 0) fgap[k] = wcnt[k];
                    wcnt[k] = 0;
                    wbnd[k] = 2;
                end else begin
                    if (mid[k]) chk("bubble", k, p0v[k], 1);
                    if (av) begin
                        wcnt[k]++;
                        chk("start_gap", k, wcnt[k] <= wbnd[k], 1);
                    end else begin
                        wcnt[k] = 0;
                        wbnd[k] = 2;
                    end
                end
                mid[k] = 1'b0;
                if (p0v[k] && ordy[k] && av) begin
                    beat[k]++;
                    if (beat[k] == nbeats(k)) begin
                        beat[k] = 0;
                        head[k] = (head[k] + f) % NBUF;
                        cnt[k]  = cnt[k] - f;
                        fdx[k]  = 1'b1;
                        tot[k]++;
                        wbnd[k] = (cnt[k] >= f) ? 1 : 2;
                    end else begin
                        mid[k] = 1'b1;
                    end
                end
                if (ld_v[k] && lre) begin
                    pbuf[k][(head[k] + cnt[k]) % NBUF] = ld_d[k];
                    cnt[k]++;
                end
            end
        end
    end

    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            if (rnd) begin
                ld_v[k] = ($urandom_range(0, 3) != 0);
                ld_d[k] = 8'($urandom);
                ordy[k] = ($urandom_range(0, 3) != 0);
            end else begin
                ld_v[k] = ld_sent[k] < target[k];
                ld_d[k] = 8'(ld_sent[k] % fsz(k));
                ordy[k] = (omode == 1) || (omode == 2 && cyc[0]);
            end
        end
    endtask

    task automatic step();
        bit acc [2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) acc[k] = ld_v[k] && lrdy[k];
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) if (acc[k]) ld_sent[k]++;
        cyc++;
    endtask

    initial begin
        int n;
        int t0 [2];
        rst = 1'b1;
        rnd = 1'b0;
        omode = 1;
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            ld_v[k] = 1'b0; ld_d[k] = '0; ordy[k] = 1'b0;
            ld_sent[k] = 0; target[k] = 0;
            tot[k] = 0; fdn[k] = 0; fgap[k] = -1;
            head[k] = 0; cnt[k] = 0; beat[k] = 0;
            fdx[k] = 1'b0; mid[k] = 1'b0; wcnt[k] = 0; wbnd[k] = 2;
        end
        repeat (3) step();
        rst = 1'b0;

        // one sequential frame, consumer always ready
        for (int k = 0; k < 2; k++) target[k] = fsz(k);
        omode = 1;
        for (n = 0; n < 300 && !(tot[0] >= 1 && tot[1] >= 1); n++) begin
            drive(); step();
        end
        chk("phase1_done", 0, tot[0] >= 1 && tot[1] >= 1, 1);
        repeat (3) begin drive(); step(); end
        chk("lit_b0_p0", 0, ob0[0][0], 0);
        chk("lit_b0_p1", 0, ob1[0][0], 8);
        chk("lit_b1_p1", 0, ob1[0][1], 9);
        chk("lit_b3_p0", 0, ob0[0][3], 3);
        chk("lit_b3_p1", 0, ob1[0][3], 11);
        chk("lit_b4_p0", 0, ob0[0][4], 16);
        chk("lit_b4_p1", 0, ob1[0][4], 24);
        chk("lit_b8_p0", 0, ob0[0][8], 4);
        chk("lit_b8_p1", 0, ob1[0][8], 12);
        chk("lit_odd_b4_p0", 1, ob0[1][4], 16);
        chk("lit_odd_b7_p0", 1, ob0[1][7], 19);
        chk("lit_odd_b4_p1v", 1, ob1v[1][4], 0);
        chk("lit_odd_b4_p1", 1, ob1[1][4], 0);
        chk("lit_odd_b12_p0", 1, ob0[1][12], 20);
        chk("lit_odd_b15_p0", 1, ob0[1][15], 23);
        chk("lit_odd_b8_p1", 1, ob1[1][8], 12);
        chk("lit_done_count", 0, fdn[0], 1);
        chk("lit_done_count", 1, fdn[1], 1);
        chk("lit_first_latency", 0, fgap[0], 2);
        chk("lit_first_latency", 1, fgap[1], 2);
`ifdef IFM_TILE_LAST_EN
        chk("lit_tile_last_b8", 0, obtl[0][7], 1);
        chk("lit_tile_last_b16", 0, obtl[0][15], 1);
        chk("lit_tile_last_b4", 0, obtl[0][3], 0);
`endif

        // consumer ready every other cycle
        for (int k = 0; k < 2; k++) target[k] += fsz(k);
        omode = 2;
        for (n = 0; n < 400 && !(tot[0] >= 2 && tot[1] >= 2); n++) begin
            drive(); step();
        end
        chk("phase2_done", 0, tot[0] >= 2 && tot[1] >= 2, 1);

        // three frames with consumer stalled, then released
        for (int k = 0; k < 2; k++) begin
            t0[k] = ld_sent[k];
            target[k] += 3 * fsz(k);
        end
        omode = 0;
        repeat (3 * 32 + 10) begin drive(); step(); end
        for (int k = 0; k < 2; k++) begin
            chk("stall_load_ready", k, lrdy[k], 0);
            chk("stall_accepted", k, ld_sent[k], t0[k] + 2 * fsz(k));
        end
        omode = 1;
        for (n = 0; n < 600 && !(tot[0] >= 5 && tot[1] >= 5); n++) begin
            drive(); step();
        end
        for (int k = 0; k < 2; k++) begin
            chk("phase3_frames", k, tot[k], 5);
            chk("phase3_third_loaded", k, ld_sent[k], target[k]);
        end

        // random traffic, then complete the partial frame and drain
        rnd = 1'b1;
        repeat (800) begin drive(); step(); end
        rnd = 1'b0;
        omode = 1;
        for (int k = 0; k < 2; k++)
            target[k] = ((ld_sent[k] + fsz(k) - 1) / fsz(k)) * fsz(k);
        for (n = 0; n < 1000 && !(cnt[0] == 0 && cnt[1] == 0 && ld_sent[0] == target[0]
                                  && ld_sent[1] == target[1]); n++) begin
            drive(); step();
        end
        chk("phase4_drained", 0, cnt[0] == 0 && cnt[1] == 0, 1);

        // reset in the middle of a frame
        for (int k = 0; k < 2; k++) target[k] = ld_sent[k] + fsz(k);
        for (n = 0; n < 200 && beat[0] != 5; n++) begin
            drive(); step();
        end
        chk("reach_beat5", 0, beat[0], 5);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) ld_v[k] = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            t0[k] = tot[k];
            target[k] = ld_sent[k] + fsz(k);
        end
        for (n = 0; n < 300 && !(tot[0] > t0[0] && tot[1] > t0[1]); n++) begin
            drive(); step();
        end
        for (int k = 0; k < 2; k++) begin
            chk("post_reset_frame", k, tot[k], t0[k] + 1);
            chk("post_reset_empty", k, cnt[k], 0);
        end
        repeat (3) begin drive(); step(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
